// File: rtl/acq_sequencer.sv
// Single-pixel-imaging acquisition sequencer: arms on START, latches one photon
// count per DMD pattern edge into memory, then streams stored counts back on READ.
module acq_sequencer #(
    parameter int unsigned N_PATTERNS  = 1000,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dmd_sig,
    input  logic [CNT_W-1:0]  cmd,
    input  logic              cmd_valid,
    input  logic [CNT_W-1:0]  cnt_in,
    output logic              cnt_clr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [CNT_W-1:0]  mem_wdata,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [CNT_W-1:0]  mem_rdata,
    output logic [CNT_W-1:0]  tx_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_ACQ,
        S_DONE,
        S_READ
    } state_t;

    // One extra index bit so the read index can reach N_PATTERNS even when
    // 2**ADDR_W == N_PATTERNS.
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(N_PATTERNS - 1);
    localparam logic [ADDR_W:0] NUM_IDX  = (ADDR_W + 1)'(N_PATTERNS);

    state_t            state;
    logic [ADDR_W:0]   idx;
    logic [ADDR_W:0]   ridx;
    logic              sat_flag;
    logic              rd_cap;
    logic [SYNC_STAGES-1:0] sync_q;
    logic              dmd_prev;
    logic              dmd_edge;
    logic              sat_hit;
    logic              cmd_abort;
    logic              cmd_start;
    logic              cmd_read;

    function automatic logic [CNT_W-1:0] status(input logic sat, input logic [1:0] code);
        logic [CNT_W-1:0] s;
        s            = '0;
        s[CNT_W-1]   = sat;
        s[1:0]       = code;
        return s;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            dmd_prev <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], dmd_sig};
            dmd_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    always_comb begin
        dmd_edge  = sync_q[SYNC_STAGES-1] & ~dmd_prev;
        sat_hit   = dmd_edge && (cnt_in == '1);
        cmd_abort = cmd_valid && (cmd == CNT_W'(0));
        cmd_start = cmd_valid && (cmd == CNT_W'(1));
        cmd_read  = cmd_valid && (cmd == CNT_W'(2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            ridx      <= '0;
            sat_flag  <= 1'b0;
            rd_cap    <= 1'b0;
            cnt_clr   <= 1'b0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            mem_re    <= 1'b0;
            mem_raddr <= '0;
            tx_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            cnt_clr <= 1'b0;
            mem_we  <= 1'b0;
            mem_re  <= 1'b0;
            // mem_rdata is valid the cycle after mem_re, so capture one cycle later
            rd_cap  <= mem_re;

            if (cmd_abort) begin
                state   <= S_IDLE;
                busy    <= 1'b0;
                done    <= 1'b0;
                rd_cap  <= 1'b0;
                tx_data <= status(sat_flag, 2'd0);
            end else if (cmd_start && (state == S_IDLE || state == S_DONE)) begin
                state    <= S_ARM;
                idx      <= '0;
                sat_flag <= 1'b0;
                rd_cap   <= 1'b0;
                busy     <= 1'b1;
                done     <= 1'b0;
                tx_data  <= status(1'b0, 2'd1);
            end else begin
                case (state)
                    S_IDLE: begin
                        tx_data <= status(sat_flag, 2'd0);
                    end
                    S_ARM: begin
                        tx_data <= status(sat_flag, 2'd1);
                        if (dmd_edge) begin
                            cnt_clr <= 1'b1;
                            state   <= S_ACQ;
                        end
                    end
                    S_ACQ: begin
                        tx_data <= status(sat_flag | sat_hit, 2'd1);
                        if (dmd_edge) begin
                            mem_we    <= 1'b1;
                            mem_waddr <= idx[ADDR_W-1:0];
                            mem_wdata <= cnt_in;
                            cnt_clr   <= 1'b1;
                            idx       <= idx + 1'b1;
                            if (sat_hit)
                                sat_flag <= 1'b1;
                            if (idx == LAST_IDX) begin
                                state   <= S_DONE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                tx_data <= status(sat_flag | sat_hit, 2'd2);
                            end
                        end
                    end
                    S_DONE: begin
                        tx_data <= status(sat_flag, 2'd2);
                        if (rd_cap) begin
                            tx_data <= mem_rdata;
                            ridx    <= (ADDR_W + 1)'(1);
                            state   <= S_READ;
                            done    <= 1'b0;
                        end else if (cmd_read && !mem_re) begin
                            mem_re    <= 1'b1;
                            mem_raddr <= '0;
                        end
                    end
                    S_READ: begin
                        if (rd_cap) begin
                            tx_data <= mem_rdata;
                            ridx    <= ridx + 1'b1;
                        end else if (cmd_read && !mem_re) begin
                            if (ridx < NUM_IDX) begin
                                mem_re    <= 1'b1;
                                mem_raddr <= ridx[ADDR_W-1:0];
                            end else begin
                                state   <= S_IDLE;
                                tx_data <= status(sat_flag, 2'd0);
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/acq_sequencer.md
Name: acq_sequencer

Overview:
Sequences one single-pixel-imaging acquisition between the SPI command interface, the 16-bit photon counter and the pattern data memory. On a host START command it arms, then on every DMD pattern trigger edge it latches the photon count into memory, clears the counter and advances the pattern index. After N_PATTERNS patterns it reports DONE. It then streams the stored counts back to the SPI tx register, one word per host READ command.

Parameters:
N_PATTERNS, 1000, number of DMD patterns per acquisition (memory depth used)
CNT_W, 16, photon count / SPI word width
ADDR_W, 10, memory address width; must satisfy 2**ADDR_W >= N_PATTERNS
SYNC_STAGES, 2, flops in the dmd_sig synchronizer (>=2)

Ports:
clk  in  1  system clock (50 MHz)
rst_n  in  1  asynchronous active-low reset
dmd_sig  in  1  DMD pattern trigger, asynchronous to clk
cmd  in  CNT_W  decoded SPI rx word; 0x0000 ABORT, 0x0001 START, 0x0002 READ
cmd_valid  in  1  one-cycle strobe, cmd valid
cnt_in  in  CNT_W  current photon count from counter
cnt_clr  out  1  one-cycle counter clear
mem_we  out  1  memory write strobe
mem_waddr  out  ADDR_W  write address
mem_wdata  out  CNT_W  write data
mem_re  out  1  memory read strobe; mem_rdata is valid on the cycle after mem_re
mem_raddr  out  ADDR_W  read address
mem_rdata  in  CNT_W  memory read data
tx_data  out  CNT_W  word loaded into SPI tx
busy  out  1  high in ARM or ACQ
done  out  1  high in DONE

Behaviour:
- All outputs are registered. Reset (async assert, sync deassert by the top level) drives every output to 0, sets state=IDLE, clears pattern index, read index and sat_flag.
- dmd_sig passes through SYNC_STAGES flops. A rising edge is detected on the synchronized copy, so an edge is seen 2–3 clk after the pad edge. Synchronizer flops reset to 0.
- Status word: {sat_flag, 13'b0, code[1:0]}, code IDLE=0, ARM/ACQ=1, DONE=2. tx_data = status word in every state except READ.
- IDLE: on cmd_valid & START, go to ARM and clear pattern index and sat_flag. All other commands are ignored.
- ARM: on the first dmd edge, pulse cnt_clr for 1 cycle and go to ACQ. No memory write occurs, because the first window starts at this edge.
- ACQ: on each dmd edge, in the same cycle: mem_we=1, mem_waddr=idx, mem_wdata=cnt_in, cnt_clr=1, idx++.
  - If cnt_in == all-ones at the latch, set sat_flag (sticky until the next START).
  - The write with idx == N_PATTERNS-1 goes to DONE on the next cycle.
- DONE: on READ, pulse mem_re with mem_raddr=0. One cycle later, tx_data = mem_rdata, ridx=1, state=READ. START in DONE behaves as in IDLE (new acquisition).
- READ: each READ command does one of two things:
  - If ridx < N_PATTERNS: mem_re with mem_raddr=ridx, tx_data updated with mem_rdata one cycle later, then ridx++.
  - If ridx == N_PATTERNS: go to IDLE and tx_data = status 0x0000 (or 0x8000 if sat_flag).
  - tx_data holds its value between commands.
- ABORT in any state goes to IDLE next cycle. No further writes or clears occur, and stored memory is untouched.
- START in ARM/ACQ/READ is ignored. READ in IDLE/ARM/ACQ is ignored.
- Abort and a dmd edge in the same cycle: abort wins, with no mem_we and no cnt_clr.
- A dmd edge in IDLE/DONE/READ is ignored and produces no cnt_clr.
- Back-to-back dmd edges on consecutive synchronized cycles are each honoured.
- Index width: idx/ridx wrap is impossible by construction. The index stops at N_PATTERNS, and the DONE transition is compared on N_PATTERNS-1.
- Async reset mid-ACQ: outputs drop to 0 immediately. Memory contents are not defined as valid.

Test Plan:
- N_PATTERNS=4; START, then 5 dmd pulses with cnt_in=10,20,30,40 before edges 2–5 -> 4 writes to addr 0..3 with data 10,20,30,40; cnt_clr pulses 5 times; done=1; tx_data=0x0002.
- From DONE, 5 READ commands -> tx_data sequence 10,20,30,40, then 0x0000 and state IDLE; mem_re pulses exactly 4 times.
- ABORT during ACQ after 2 writes -> IDLE within 1 cycle; busy=0; tx_data=0x0000; later dmd edges cause no write or clear.
- ABORT strobed on the same cycle as a synchronized dmd edge -> no mem_we, no cnt_clr, state IDLE.
- cnt_in=0xFFFF at one latch -> sat_flag set; DONE status reads 0x8002; next START clears it (status 0x0001).
- Assert rst_n low mid-ACQ -> all outputs 0 asynchronously; after release, a READ is ignored and START works normally.
